// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data RAM port arbiter.
package mem_port_arbiter_pkg;

  // Port identifiers carried in the read-return tag.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Deepest RAM read latency the tag pipe is meant to cover.
  localparam int unsigned RD_LAT_MAX = 4;

  // One in-flight read: whether it exists and which port owns the return.
  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, RAM port and perf counters around the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned CNT_W  = 32
);

  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic [31:0]       d_addr;
  logic [3:0]        d_wmask;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_wmask;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  confl_cnt;

  // Core-side requesters plus the RAM macro.
  modport master (
    output i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  ram_en, ram_addr, ram_wmask, ram_wdata, wait_cnt, confl_cnt
  );

  // The arbiter itself.
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, ram_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output ram_en, ram_addr, ram_wmask, ram_wdata, wait_cnt, confl_cnt
  );

endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags, aligned with the RAM read latency.
module mem_port_arbiter_rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [RD_LAT];

  // Shift tags one stage per cycle; reset drops every in-flight return.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access.
// Data has priority; fetch is forced through after MAX_STREAK data grants in a row.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned CNT_W      = 32
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT out of range");
  end
  if (MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_bad_streak
    $error("mem_port_arbiter: MAX_STREAK out of range");
  end

  localparam logic [3:0] StreakMax = 4'(MAX_STREAK);

  logic             i_gnt, d_gnt;
  logic             i_rvalid, d_rvalid;
  logic [3:0]       streak_q, streak_d;
  logic [31:0]      i_hold_q, d_hold_q;
  logic [CNT_W-1:0] wait_cnt_q, confl_cnt_q;
  rd_tag_t          tag_in, tag_out;

  // Byte-offset and out-of-range address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[1:0], bus.i_addr[31:ADDR_W+2],
                              bus.d_addr[1:0], bus.d_addr[31:ADDR_W+2]};

  // Same-cycle grant: data first unless fetch has waited through a full streak.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (bus.d_req && (!bus.i_req || streak_q != StreakMax)) begin
        d_gnt = 1'b1;
      end else if (bus.i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Steer the granted port onto the RAM; idle RAM inputs are parked at zero.
  always_comb begin
    bus.ram_en    = i_gnt | d_gnt;
    bus.ram_addr  = '0;
    bus.ram_wmask = 4'b0000;
    bus.ram_wdata = '0;
    if (d_gnt) begin
      bus.ram_addr  = bus.d_addr[ADDR_W+1:2];
      bus.ram_wmask = bus.d_wmask;
      bus.ram_wdata = bus.d_wdata;
    end else if (i_gnt) begin
      bus.ram_addr  = bus.i_addr[ADDR_W+1:2];
    end
  end

  assign bus.i_gnt = i_gnt;
  assign bus.d_gnt = d_gnt;

  // Only reads enter the pipe; stores never produce a return.
  always_comb begin
    tag_in.valid = i_gnt | (d_gnt & (bus.d_wmask == 4'b0000));
    tag_in.port  = d_gnt ? PORT_D : PORT_I;
  end

  mem_port_arbiter_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign i_rvalid = ~reset & tag_out.valid & (tag_out.port == PORT_I);
  assign d_rvalid = ~reset & tag_out.valid & (tag_out.port == PORT_D);

  assign bus.i_rvalid = i_rvalid;
  assign bus.d_rvalid = d_rvalid;
  assign bus.i_rdata  = i_rvalid ? bus.ram_rdata : i_hold_q;
  assign bus.d_rdata  = d_rvalid ? bus.ram_rdata : d_hold_q;

  // Count data grants taken while fetch waits; any fetch grant or fetch idle clears it.
  always_comb begin
    streak_d = streak_q;
    if (!bus.i_req || i_gnt) begin
      streak_d = 4'd0;
    end else if (d_gnt && streak_q != StreakMax) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // Streak state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end

  // Capture each return so rdata stays stable until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      if (i_rvalid) i_hold_q <= bus.ram_rdata;
      if (d_rvalid) d_hold_q <= bus.ram_rdata;
    end
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      confl_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_q + CNT_W'(bus.i_req & ~i_gnt);
      confl_cnt_q <= confl_cnt_q + CNT_W'(bus.i_req & bus.d_req);
    end
  end

  assign bus.wait_cnt  = wait_cnt_q;
  assign bus.confl_cnt = confl_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: RAM behavioural model plus a transaction-level reference of the arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned MAX_STREAK = 4;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned DEPTH      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .RD_LAT     (RD_LAT),
    .MAX_STREAK (MAX_STREAK),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input int unsigned i);
    return ((i + 1) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // RAM environment: RD_LAT read latency, garbage on ram_rdata when no read is due.
  logic [31:0] ram_mem [DEPTH];
  logic [31:0] rd_line [RD_LAT];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = init_word(i);
      for (int k = 0; k < RD_LAT; k++) rd_line[k] = 32'h0;
      ram_ready = 1'b1;
    end
    if (bus.ram_en && bus.ram_wmask != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_wmask[b]) ram_mem[bus.ram_addr][8*b +: 8] = bus.ram_wdata[8*b +: 8];
    end
    for (int k = RD_LAT - 1; k > 0; k--) rd_line[k] = rd_line[k-1];
    rd_line[0] = (bus.ram_en && bus.ram_wmask == 4'b0000) ? ram_mem[bus.ram_addr] : $urandom;
    bus.ram_rdata <= rd_line[RD_LAT-1];
  end

  // Reference model state.
  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } ret_t;

  logic [31:0]      mdl_mem [DEPTH];
  ret_t             pend [$];
  logic [31:0]      hold_i, hold_d;
  int               streak;
  logic [CNT_W-1:0] wait_m, confl_m;
  int               cyc;
  int               n_assert = 0;
  int               n_fail   = 0;

  // Observations of the last sampled cycle, for directed checks.
  bit               obs_dg, obs_iv, obs_dv;
  logic [CNT_W-1:0] obs_wait, obs_confl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check every output against the model, advance the model.
  task automatic cycle(input bit rst, input bit ir, input logic [31:0] ia,
                       input bit dr, input logic [31:0] da, input logic [3:0] dm,
                       input logic [31:0] dw, output bit gi, output bit gd);
    bit          ev_i, ev_d;
    logic [31:0] ret_data;
    int unsigned w;
    ret_t        r;
    reset       = rst;
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_addr  = da;
    bus.d_wmask = dm;
    bus.d_wdata = dw;
    #1;
    gi = 1'b0;
    gd = 1'b0;
    if (!rst) begin
      if (ir && dr) begin
        if (streak >= MAX_STREAK) gi = 1'b1;
        else gd = 1'b1;
      end else if (dr) gd = 1'b1;
      else if (ir) gi = 1'b1;
    end
    w = ((gd ? da : ia) >> 2) % DEPTH;
    ev_i = 1'b0;
    ev_d = 1'b0;
    ret_data = '0;
    if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port) ev_d = 1'b1;
      else ev_i = 1'b1;
      ret_data = pend[0].data;
    end
    obs_dg    = bus.d_gnt;
    obs_iv    = bus.i_rvalid;
    obs_dv    = bus.d_rvalid;
    obs_wait  = bus.wait_cnt;
    obs_confl = bus.confl_cnt;
    check("i_gnt", 64'(bus.i_gnt), 64'(gi));
    check("d_gnt", 64'(bus.d_gnt), 64'(gd));
    check("ram_en", 64'(bus.ram_en), 64'(gi | gd));
    if (gi || gd) begin
      check("ram_addr", 64'(bus.ram_addr), 64'(w));
      check("ram_wmask", 64'(bus.ram_wmask), gd ? 64'(dm) : 64'd0);
      check("ram_wdata", 64'(bus.ram_wdata), gd ? 64'(dw) : 64'd0);
    end
    check("i_rvalid", 64'(bus.i_rvalid), 64'(ev_i));
    check("d_rvalid", 64'(bus.d_rvalid), 64'(ev_d));
    check("i_rdata", 64'(bus.i_rdata), 64'(ev_i ? ret_data : hold_i));
    check("d_rdata", 64'(bus.d_rdata), 64'(ev_d ? ret_data : hold_d));
    check("wait_cnt", 64'(bus.wait_cnt), 64'(wait_m));
    check("confl_cnt", 64'(bus.confl_cnt), 64'(confl_m));
    if (rst) begin
      pend.delete();
      hold_i  = '0;
      hold_d  = '0;
      streak  = 0;
      wait_m  = '0;
      confl_m = '0;
    end else begin
      if (ir && !gi) wait_m++;
      if (ir && dr) confl_m++;
      if (ev_i) hold_i = ret_data;
      if (ev_d) hold_d = ret_data;
      if (ev_i || ev_d) void'(pend.pop_front());
      if (gd && dm != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (dm[b]) mdl_mem[w][8*b +: 8] = dw[8*b +: 8];
      end else if (gi || gd) begin
        r.due  = cyc + int'(RD_LAT);
        r.port = gd;
        r.data = mdl_mem[w];
        pend.push_back(r);
      end
      if (ir && gd) streak = (streak < MAX_STREAK) ? streak + 1 : streak;
      else streak = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit gi, gd;
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, 1'b0, '0, 4'h0, '0, gi, gd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit               gi, gd, ir, dr, rst;
    logic [31:0]      ia, da, dw, t;
    logic [3:0]       dm;
    logic [9:0]       ord;
    logic [CNT_W-1:0] w0, c0;
    int               nrv;

    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = init_word(i);
    hold_i = '0; hold_d = '0; streak = 0; wait_m = '0; confl_m = '0; cyc = 0;
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0;
    bus.d_addr = '0; bus.d_wmask = '0; bus.d_wdata = '0;
    @(negedge clk);

    // Reset, then the model's zeroed state is checked on the idle cycle.
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 4'h0, '0, gi, gd);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 4'h0, '0, gi, gd);
    idle(1);

    // Fetch-only read at 0x10 -> word 4.
    cycle(1'b0, 1'b1, 32'h10, 1'b0, '0, 4'h0, '0, gi, gd);
    idle(RD_LAT + 1);
    check("fetch_word4", 64'(bus.i_rdata), 64'(init_word(4)));

    // Partial store then readback at 0x20 -> word 8.
    cycle(1'b0, 1'b0, '0, 1'b1, 32'h20, 4'b0011, 32'hDEADBEEF, gi, gd);
    idle(RD_LAT + 1);
    cycle(1'b0, 1'b0, '0, 1'b1, 32'h20, 4'b0000, '0, gi, gd);
    idle(RD_LAT + 1);
    t = init_word(8);
    check("partial_store", 64'(bus.d_rdata), 64'({t[31:16], 16'hBEEF}));

    // Both ports requesting for 10 cycles: streak cap forces fetch every 5th.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 32'h4 * k, 1'b1, 32'h80 + 32'h4 * k, 4'h0, '0, gi, gd);
      ord[k] = obs_dg;
      if (k == 0) begin
        w0 = obs_wait;
        c0 = obs_confl;
      end
    end
    idle(1);
    check("grant_order", 64'(ord), 64'(10'b0111101111));
    check("wait_delta", 64'(obs_wait - w0), 64'd8);
    check("confl_delta", 64'(obs_confl - c0), 64'd10);
    idle(RD_LAT + 1);

    // Alternating back-to-back fetch/data reads.
    for (int k = 0; k < 8; k++)
      cycle(1'b0, k % 2 == 0, 32'h100 + 32'h4 * k, k % 2 == 1, 32'h40 + 32'h4 * k,
            4'h0, '0, gi, gd);
    idle(RD_LAT + 1);

    // Reset one cycle after a read grant: the return must vanish.
    cycle(1'b0, 1'b0, '0, 1'b1, 32'h14, 4'h0, '0, gi, gd);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 4'h0, '0, gi, gd);
    nrv = 0;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      idle(1);
      nrv += int'(obs_iv) + int'(obs_dv);
    end
    check("reset_drop_rvalid", 64'(nrv), 64'd0);
    check("reset_i_rdata", 64'(bus.i_rdata), 64'd0);
    check("reset_d_rdata", 64'(bus.d_rdata), 64'd0);

    // Returned data held across idle cycles while ram_rdata wanders.
    cycle(1'b0, 1'b0, '0, 1'b1, 32'h40, 4'hF, 32'h12345678, gi, gd);
    cycle(1'b0, 1'b0, '0, 1'b1, 32'h40, 4'h0, '0, gi, gd);
    idle(RD_LAT + 5);
    check("hold_d_rdata", 64'(bus.d_rdata), 64'h12345678);

    // Request high while leaving reset: arbitration must be live immediately.
    cycle(1'b1, 1'b1, 32'hFFFF_FF0C, 1'b0, '0, 4'h0, '0, gi, gd);
    cycle(1'b0, 1'b1, 32'hFFFF_FF0C, 1'b0, '0, 4'h0, '0, gi, gd);
    idle(RD_LAT + 1);

    // Random traffic obeying the hold-until-grant protocol.
    ir = 1'b0; dr = 1'b0; ia = '0; da = '0; dm = '0; dw = '0;
    for (int n = 0; n < 500; n++) begin
      if (!ir && $urandom_range(0, 99) < 60) begin
        ir = 1'b1;
        ia = $urandom;
      end
      if (!dr && $urandom_range(0, 99) < 60) begin
        dr = 1'b1;
        da = $urandom;
        dm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        dw = $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle(rst, ir, ia, dr, da, dm, dw, gi, gd);
      if (gi) ir = 1'b0;
      if (gd) dr = 1'b0;
    end
    idle(RD_LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
